// File: rtl/f_fetch_stage_pkg.sv
// Shared encodings for the F stage: SelPCsrc values, nop word, reset PC, fetch FSM states.
package f_fetch_stage_pkg;

  typedef enum logic [2:0] {
    NO_BRANCH  = 3'b000,
    BEQ_BRANCH = 3'b001,
    JAL_JUMP   = 3'b010,
    JR_JUMP    = 3'b011
  } sel_pc_e;

  typedef enum logic {
    S_REQ  = 1'b0,
    S_HOLD = 1'b1
  } fetch_state_e;

  localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_3000;

endpackage

// File: rtl/f_fetch_stage_npc_calc.sv
// Branch/jump target and taken decision for the instruction sitting in D.
module f_npc_calc
  import f_fetch_stage_pkg::*;
(
  input  logic [2:0]  sel_i,
  input  logic        cmp_i,
  input  logic [31:0] d_pc_i,
  input  logic [25:0] d_instr_i,
  input  logic [31:0] rs_data_i,
  output logic [31:0] target_o,
  output logic        take_o
);

  logic [31:0] br_off;

  assign br_off = {{14{d_instr_i[15]}}, d_instr_i[15:0], 2'b00};

  always_comb begin
    target_o = d_pc_i + 32'd4;
    take_o   = 1'b0;
    case (sel_i)
      BEQ_BRANCH: begin
        target_o = d_pc_i + 32'd4 + br_off;
        take_o   = cmp_i;
      end
      JAL_JUMP: begin
        target_o = {d_pc_i[31:28], d_instr_i[25:0], 2'b00};
        take_o   = 1'b1;
      end
      JR_JUMP: begin
        target_o = rs_data_i;
        take_o   = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/f_fetch_stage.sv
// F stage: PC, instruction-memory handshake and IF/ID register, with delay-slot redirects.
module f_fetch_stage
  import f_fetch_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall_i,
  input  logic [2:0]  d_sel_pc_src_i,
  input  logic        d_cmp_true_i,
  input  logic [31:0] d_rs_data_i,
  output logic        im_req_o,
  output logic [31:0] im_addr_o,
  input  logic        im_ack_i,
  input  logic [31:0] im_rdata_i,
  output logic [31:0] d_pc_o,
  output logic [31:0] d_instr_o,
  output logic        d_valid_o
);

  fetch_state_e state_q;
  logic [31:0]  pc_q, d_pc_q, d_instr_q, buf_q, redir_pc_q;
  logic         d_valid_q, redir_valid_q;
  logic [31:0]  target, npc_d;
  logic         take, take_now;

  f_npc_calc u_npc (
    .sel_i     (d_sel_pc_src_i),
    .cmp_i     (d_cmp_true_i),
    .d_pc_i    (d_pc_q),
    .d_instr_i (d_instr_q[25:0]),
    .rs_data_i (d_rs_data_i),
    .target_o  (target),
    .take_o    (take)
  );

  assign take_now = d_valid_q & ~stall_i & take;

  // A latched redirect belongs to an older branch than whatever is in D now.
  always_comb begin
    npc_d = pc_q + 32'd4;
    if (redir_valid_q)  npc_d = redir_pc_q;
    else if (take_now)  npc_d = target;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= S_REQ;
      pc_q          <= RESET_PC;
      d_pc_q        <= RESET_PC;
      d_instr_q     <= NOP_INSTR;
      d_valid_q     <= 1'b0;
      buf_q         <= NOP_INSTR;
      redir_valid_q <= 1'b0;
      redir_pc_q    <= RESET_PC;
    end else begin
      case (state_q)
        S_REQ: begin
          if (im_ack_i) begin
            if (!stall_i) begin
              d_pc_q        <= pc_q;
              d_instr_q     <= im_rdata_i;
              d_valid_q     <= 1'b1;
              pc_q          <= npc_d;
              redir_valid_q <= 1'b0;
            end else begin
              buf_q   <= im_rdata_i;
              state_q <= S_HOLD;
            end
          end else if (!stall_i) begin
            // D drains into a bubble; remember the redirect since D forgets the branch.
            d_instr_q <= NOP_INSTR;
            d_valid_q <= 1'b0;
            if (take_now) begin
              redir_pc_q    <= target;
              redir_valid_q <= 1'b1;
            end
          end
        end
        S_HOLD: begin
          if (!stall_i) begin
            d_pc_q        <= pc_q;
            d_instr_q     <= buf_q;
            d_valid_q     <= 1'b1;
            pc_q          <= npc_d;
            redir_valid_q <= 1'b0;
            state_q       <= S_REQ;
          end
        end
        default: state_q <= S_REQ;
      endcase
    end
  end

  assign im_req_o  = (state_q == S_REQ) & ~reset;
  assign im_addr_o = pc_q;
  assign d_pc_o    = d_pc_q;
  assign d_instr_o = d_instr_q;
  assign d_valid_o = d_valid_q;

endmodule

// File: doc/f_fetch_stage.md
Name: f_fetch_stage

Overview:
- Pipeline F stage: owns the PC register, the instruction-memory request handshake and the IF/ID pipeline register that feeds the D stage.
- Consumes the D-stage decode results: SelPCsrc from the general controller, the beq comparator result, and the D-stage rs data.
- Produces the next PC and the D-stage {pc, instr, valid}.
- Uses a branch-delay-slot model: the instruction after a branch or jump always executes.

Parameters:
- RESET_PC, 32'h0000_3000, PC loaded on reset.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- stall_i  in  1  hazard-unit stall; holds the IF/ID register, and the PC once a fetch completes.
- d_sel_pc_src_i  in  3  controller SelPCsrc for the D instruction: 0 none, 1 beq, 2 jal, 3 jr.
- d_cmp_true_i  in  1  beq comparator result.
- d_rs_data_i  in  32  forwarded rs value, used as the jr target.
- im_req_o  out  1  instruction-memory request.
- im_addr_o  out  32  fetch address.
- im_ack_i  in  1  one-cycle acknowledge; may be asserted in the same cycle as the request.
- im_rdata_i  in  32  instruction word, valid when im_ack_i=1.
- d_pc_o  out  32  IF/ID PC.
- d_instr_o  out  32  IF/ID instruction.
- d_valid_o  out  1  IF/ID holds a real instruction.

Behaviour:
- Reset values:
  - pc = RESET_PC; state = S_REQ.
  - d_pc_o = RESET_PC; d_instr_o = 0 (nop); d_valid_o = 0.
  - redir_valid = 0.
  - im_req_o = 0 during the reset cycle.
  - im_ack_i is ignored while reset=1.
- Outputs from state and PC:
  - im_req_o = (state==S_REQ) & ~reset.
  - im_addr_o = pc, held stable until acknowledged.
- Branch/jump target, computed from the D stage:
  - beq: d_pc_o + 4 + (sext(d_instr_o[15:0]) << 2).
  - jal: {d_pc_o[31:28], d_instr_o[25:0], 2'b00}.
  - jr: d_rs_data_i.
- take_now = d_valid_o & ~stall_i & ((sel==1 & d_cmp_true_i) | sel==2 | sel==3).
- npc priority on a completing fetch:
  1. redir_valid → redir_pc.
  2. take_now → target.
  3. otherwise pc + 4.
- FSM, S_REQ:
  - ack & ~stall: IF/ID <= {pc, im_rdata_i, 1}; pc <= npc; redir_valid <= 0; stay in S_REQ.
  - ack & stall: buf <= im_rdata_i; IF/ID holds; go to S_HOLD.
  - ~ack & ~stall: IF/ID <= {d_pc_o, 0, 0} (bubble). If take_now, latch redir_pc <= target and redir_valid <= 1.
  - ~ack & stall: everything holds.
- FSM, S_HOLD:
  - im_req_o = 0.
  - On ~stall: IF/ID <= {pc, buf, 1}; pc <= npc; clear redir_valid; go to S_REQ.
- Redirect rules:
  - A redirect is latched at most once, because the delay slot is always the pending fetch.
  - A taken branch in D while stalled does nothing; it is re-evaluated when D advances.
- Zero-wait IM (ack in the request cycle) gives one instruction per cycle; IF/ID latency is 1 cycle after the ack.
- Reset mid-fetch or in S_HOLD: the fetch is abandoned, buf is discarded, redir_valid is cleared, and the next request is to RESET_PC.
- Arithmetic is 32-bit and wraps modulo 2^32.

Decomposition:
- Shared package:
  - SelPCsrc encodings: NO_BRANCH=3'b000, BEQ_BRANCH=3'b001, JAL_JUMP=3'b010, JR_JUMP=3'b011.
  - NOP_INSTR = 32'h0.
  - Default RESET_PC.
  - FSM state constants S_REQ, S_HOLD.
- Sub-module f_npc_calc: combinational target and take_now logic. Inputs: sel, cmp, d_pc, d_instr, rs_data. Outputs: target, take.

Test Plan:
1. Reset, then zero-wait IM:
   - im_addr_o is 0x3000, 0x3004, 0x3008 on consecutive cycles.
   - d_pc_o follows one cycle behind each, with d_valid_o=1.
2. IM ack 2 cycles after each request:
   - Each waiting cycle gives d_valid_o=0 and d_instr_o=0.
   - PCs are delivered in order, none skipped.
3. beq at 0x3004 with imm 16'h0003 and cmp=1:
   - 0x3008 (delay slot) is fetched, then 0x3014.
   - Repeat with 3-cycle IM latency: the redirect is latched and the sequence is identical.
   - Repeat with cmp=0: 0x300C is fetched next.
4. jal at 0x3000 with index 26'h0000C05:
   - 0x3004 is fetched, then 0x3014.
   - jr at 0x3014 with rs=0x3100: 0x3018 is fetched, then 0x3100.
5. stall_i high for 2 cycles, with ack arriving in the first stalled cycle:
   - State goes to S_HOLD with im_req_o=0, and D holds.
   - The buffered word appears in D the cycle after stall drops; no duplicates or losses.
6. reset asserted while waiting for ack with a redirect latched:
   - Outputs return to reset values and redir_valid=0.
   - The next im_addr_o is 0x3000.
